// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stall controller:
//   REG_IDX_W            width of a register index in the pipeline
//   MEM_TIMEOUT_DEFAULT  default busy-cycle limit for the memory watchdog
//   stall_state_t        controller states (RUN, LU_STALL, HALT, STEP)
//   src_match()          true when a nonzero source index equals a dest index
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int REG_IDX_W           = 6;
  localparam int MEM_TIMEOUT_DEFAULT = 1023;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    HALT     = 2'd2,
    STEP     = 2'd3
  } stall_state_t;

  // Index 0 means "operand not used", so it can never create a dependency.
  function automatic logic src_match(input logic [REG_IDX_W-1:0] dest,
                                     input logic [REG_IDX_W-1:0] src);
    return (src != '0) && (src == dest);
  endfunction

endpackage

// File: rtl/pipe_wdog.sv
// ---------------------------------------------------------------------------
// pipe_wdog
// Memory-busy watchdog. Counts consecutive busy cycles (saturating at
// MEM_TIMEOUT) and raises a sticky timeout flag once the count reaches the
// limit. Only reset clears the flag.
// Ports:
//   clk      clock
//   rst      synchronous active-low reset
//   busy     data memory busy
//   timeout  sticky timeout flag
// ---------------------------------------------------------------------------
module pipe_wdog
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  output logic timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // The counter runs only across an unbroken stretch of busy cycles and
  // restarts on the first idle cycle. The flag is set on the same edge that
  // brings the count up to the limit, so it is visible right after the
  // MEM_TIMEOUT-th busy cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else if (busy) begin
      if (cnt != LIMIT) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (cnt >= LIMIT - CNT_W'(1)) begin
        timeout <= 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
// Central stall controller for the 5-stage pipeline. Generates PC hold and
// the pause signals of the FI_ID, ID_EX, EX_MEM and MEM_WB stage registers.
// Handles load-use bubbles, freezes everything while data memory is busy and
// supports debug halt / single-step.
//
// Hazards are resolved into the state register, so pause outputs depend only
// on the state, dmem_busy_i and rst.
//
// Optional feature: define PIPE_PERF_CNT_EN to build the stall-cycle
// performance counter; otherwise stall_cycles_o is tied to 0.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   if_rs_i, if_rt_i    source indices of the raw fetched instruction
//   id_load_i           ID instruction is a load
//   id_dest_i           destination index of that load
//   dmem_busy_i         data memory busy
//   halt_req_i          debug halt request (level)
//   step_i              single-step pulse (used only in HALT)
//   pc_hold_o           PC does not advance
//   pause_*_o           stage-register pauses
//   halted_o            core is in HALT
//   mem_timeout_o       sticky memory timeout
//   stall_cycles_o      stall-cycle counter
// ---------------------------------------------------------------------------
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] if_rs_i,
  input  logic [REG_IDX_W-1:0] if_rt_i,
  input  logic                 id_load_i,
  input  logic [REG_IDX_W-1:0] id_dest_i,
  input  logic                 dmem_busy_i,
  input  logic                 halt_req_i,
  input  logic                 step_i,
  output logic                 pc_hold_o,
  output logic                 pause_fi_id_o,
  output logic                 pause_id_ex_o,
  output logic                 pause_ex_mem_o,
  output logic                 pause_mem_wb_o,
  output logic                 halted_o,
  output logic                 mem_timeout_o,
  output logic [31:0]          stall_cycles_o
);

  stall_state_t state;
  stall_state_t next_state;
  logic         hazard;

  // Load-use hazard: the load in ID writes a register the fetched
  // instruction is about to read.
  assign hazard = id_load_i && (id_dest_i != '0) &&
                  (src_match(id_dest_i, if_rs_i) || src_match(id_dest_i, if_rt_i));

  // State register. A busy memory freezes the state, so a pending stall or
  // step survives the freeze and is performed once memory is free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
    end else if (!dmem_busy_i) begin
      state <= next_state;
    end
  end

  // Next-state logic. Hazards beat halt requests in RUN/STEP; in HALT a
  // step pulse beats a dropped halt request.
  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (hazard) begin
          next_state = LU_STALL;
        end else if (halt_req_i) begin
          next_state = HALT;
        end
      end
      LU_STALL: begin
        next_state = halt_req_i ? HALT : RUN;
      end
      HALT: begin
        if (step_i) begin
          next_state = STEP;
        end else if (!halt_req_i) begin
          next_state = RUN;
        end
      end
      STEP: begin
        if (hazard) begin
          next_state = LU_STALL;
        end else begin
          next_state = halt_req_i ? HALT : RUN;
        end
      end
      default: next_state = RUN;
    endcase
  end

  // Output logic. Reset and memory freeze override the per-state outputs;
  // halted_o still follows the state during a freeze but is 0 in reset.
  always_comb begin
    pc_hold_o      = 1'b0;
    pause_fi_id_o  = 1'b0;
    pause_id_ex_o  = 1'b0;
    pause_ex_mem_o = 1'b0;
    pause_mem_wb_o = 1'b0;
    halted_o       = 1'b0;
    if (!rst) begin
      pc_hold_o      = 1'b1;
      pause_fi_id_o  = 1'b1;
      pause_id_ex_o  = 1'b1;
      pause_ex_mem_o = 1'b1;
      pause_mem_wb_o = 1'b1;
    end else if (dmem_busy_i) begin
      pc_hold_o      = 1'b1;
      pause_fi_id_o  = 1'b1;
      pause_id_ex_o  = 1'b1;
      pause_ex_mem_o = 1'b1;
      pause_mem_wb_o = 1'b1;
      halted_o       = (state == HALT);
    end else begin
      case (state)
        LU_STALL: begin
          pc_hold_o     = 1'b1;
          pause_fi_id_o = 1'b1;
        end
        HALT: begin
          pc_hold_o      = 1'b1;
          pause_fi_id_o  = 1'b1;
          pause_id_ex_o  = 1'b1;
          pause_ex_mem_o = 1'b1;
          pause_mem_wb_o = 1'b1;
          halted_o       = 1'b1;
        end
        default: begin
          pc_hold_o = 1'b0;
        end
      endcase
    end
  end

  pipe_wdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .busy    (dmem_busy_i),
    .timeout (mem_timeout_o)
  );

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic        count_en;

  // Counts cycles lost to hazards and memory; a quiet debug halt is not
  // a stall, but a frozen halt cycle is.
  assign count_en = pc_hold_o && !((state == HALT) && !dmem_busy_i);

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (count_en) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Directed bench for pipe_stall_ctrl built with MEM_TIMEOUT = 4.
// Output vector layout: {pc_hold, fi_id, id_ex, ex_mem, mem_wb, halted}.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  localparam logic [5:0] ALL0 = 6'b000000;
  localparam logic [5:0] LU   = 6'b110000;
  localparam logic [5:0] FRZ  = 6'b111110;
  localparam logic [5:0] HLT  = 6'b111111;
  localparam logic [5:0] RST  = 6'b111110;

  logic        clk;
  logic        rst;
  logic [5:0]  if_rs;
  logic [5:0]  if_rt;
  logic        id_load;
  logic [5:0]  id_dest;
  logic        dmem_busy;
  logic        halt_req;
  logic        step;
  logic        pc_hold;
  logic        pause_fi_id;
  logic        pause_id_ex;
  logic        pause_ex_mem;
  logic        pause_mem_wb;
  logic        halted;
  logic        mem_timeout;
  logic [31:0] stall_cycles;

  typedef struct {
    string      tag;
    logic [5:0] vec;
  } exp_t;

  exp_t        exp_q[$];
  int          total;
  int          bad;
  logic [31:0] exp_perf;

  pipe_stall_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_rs_i        (if_rs),
    .if_rt_i        (if_rt),
    .id_load_i      (id_load),
    .id_dest_i      (id_dest),
    .dmem_busy_i    (dmem_busy),
    .halt_req_i     (halt_req),
    .step_i         (step),
    .pc_hold_o      (pc_hold),
    .pause_fi_id_o  (pause_fi_id),
    .pause_id_ex_o  (pause_id_ex),
    .pause_ex_mem_o (pause_ex_mem),
    .pause_mem_wb_o (pause_mem_wb),
    .halted_o       (halted),
    .mem_timeout_o  (mem_timeout),
    .stall_cycles_o (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pops the oldest expectation and compares it with the live outputs.
  task automatic checkOutput();
    exp_t       e;
    logic [5:0] obs;
    obs = {pc_hold, pause_fi_id, pause_id_ex, pause_ex_mem, pause_mem_wb, halted};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("[TB] FAIL scoreboard_empty observed=%b expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.vec) else begin
        bad++;
        $error("[TB] FAIL %s observed=%b expected=%b", e.tag, obs, e.vec);
      end
    end
  endtask

  task automatic checkScalar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, queues the outputs expected during that
  // cycle, checks them, then advances past the next rising edge. The perf
  // model accumulates on the edge that ends the cycle.
  task automatic applyStimulus(input string tag, input logic r, input logic ld,
                               input logic [5:0] dest, input logic [5:0] rs,
                               input logic [5:0] rt, input logic busy,
                               input logic hreq, input logic stp,
                               input logic [5:0] e);
    exp_t item;
    rst       = r;
    id_load   = ld;
    id_dest   = dest;
    if_rs     = rs;
    if_rt     = rt;
    dmem_busy = busy;
    halt_req  = hreq;
    step      = stp;
    item.tag  = tag;
    item.vec  = e;
    exp_q.push_back(item);
    #2;
    checkOutput();
    if (!r) begin
      exp_perf = 32'd0;
    end else if (e[5] && !(e[0] && !busy)) begin
      exp_perf = exp_perf + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] perfExp(input logic [31:0] v);
`ifdef PIPE_PERF_CNT_EN
    return v;
`else
    return (v & 32'd0);
`endif
  endfunction

  initial begin
    total    = 0;
    bad      = 0;
    exp_perf = 32'd0;
    rst = 1'b0; id_load = 1'b0; id_dest = '0; if_rs = '0; if_rt = '0;
    dmem_busy = 1'b0; halt_req = 1'b0; step = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    applyStimulus("reset0", 0, 0, 0, 0, 0, 0, 0, 0, RST);
    applyStimulus("reset1", 0, 0, 0, 0, 0, 0, 0, 0, RST);
    checkScalar("reset_timeout", {31'd0, mem_timeout}, 32'd0);
    checkScalar("reset_perf", stall_cycles, 32'd0);
    applyStimulus("idle_run", 1, 0, 0, 0, 0, 0, 0, 0, ALL0);

    // Load-use via rt, then via rs
    applyStimulus("lu_rt_sample", 1, 1, 5, 0, 5, 0, 0, 0, ALL0);
    applyStimulus("lu_rt_stall",  1, 0, 0, 0, 0, 0, 0, 0, LU);
    applyStimulus("lu_rt_after",  1, 0, 0, 0, 0, 0, 0, 0, ALL0);
    applyStimulus("lu_rs_sample", 1, 1, 7, 7, 0, 0, 0, 0, ALL0);
    applyStimulus("lu_rs_stall",  1, 0, 0, 0, 0, 0, 0, 0, LU);
    applyStimulus("lu_rs_after",  1, 0, 0, 0, 0, 0, 0, 0, ALL0);

    // Register 0 and non-load never hazard
    applyStimulus("r0_a",     1, 1, 0, 0, 0, 0, 0, 0, ALL0);
    applyStimulus("r0_b",     1, 1, 3, 0, 9, 0, 0, 0, ALL0);
    applyStimulus("noload",   1, 0, 4, 4, 4, 0, 0, 0, ALL0);
    applyStimulus("r0_after", 1, 0, 0, 0, 0, 0, 0, 0, ALL0);

    // Freeze over a pending stall, then perf count of 3 freeze + 1 stall
    applyStimulus("frz_reset",  0, 0, 0, 0, 0, 0, 0, 0, RST);
    applyStimulus("frz_idle",   1, 0, 0, 0, 0, 0, 0, 0, ALL0);
    applyStimulus("frz_hazard", 1, 1, 5, 0, 5, 0, 0, 0, ALL0);
    applyStimulus("frz_busy1",  1, 0, 0, 0, 0, 1, 0, 0, FRZ);
    applyStimulus("frz_busy2",  1, 0, 0, 0, 0, 1, 0, 0, FRZ);
    applyStimulus("frz_busy3",  1, 0, 0, 0, 0, 1, 0, 0, FRZ);
    applyStimulus("frz_lu",     1, 0, 0, 0, 0, 0, 0, 0, LU);
    applyStimulus("frz_run",    1, 0, 0, 0, 0, 0, 0, 0, ALL0);
    checkScalar("perf_four", stall_cycles, perfExp(32'd4));
    checkScalar("frz_no_timeout", {31'd0, mem_timeout}, 32'd0);

    // Halt, step, resume
    applyStimulus("halt_req",    1, 0, 0, 0, 0, 0, 1, 0, ALL0);
    applyStimulus("halt_in",     1, 0, 0, 0, 0, 0, 1, 0, HLT);
    applyStimulus("halt_step",   1, 0, 0, 0, 0, 0, 1, 1, HLT);
    applyStimulus("step_cycle",  1, 0, 0, 0, 0, 0, 1, 0, ALL0);
    applyStimulus("step_rehalt", 1, 0, 0, 0, 0, 0, 1, 0, HLT);
    applyStimulus("halt_busy",   1, 0, 0, 0, 0, 1, 1, 0, HLT);
    applyStimulus("halt_drop",   1, 0, 0, 0, 0, 0, 0, 0, HLT);
    applyStimulus("resume_run",  1, 0, 0, 0, 0, 0, 0, 0, ALL0);

    // Hazard beats halt in RUN, and a hazard during STEP stalls
    applyStimulus("hz_halt_smp", 1, 1, 2, 2, 0, 0, 1, 0, ALL0);
    applyStimulus("hz_halt_lu",  1, 0, 0, 0, 0, 0, 1, 0, LU);
    applyStimulus("hz_halt_hlt", 1, 0, 0, 0, 0, 0, 1, 1, HLT);
    applyStimulus("step_hazard", 1, 1, 6, 0, 6, 0, 1, 0, ALL0);
    applyStimulus("step_lu",     1, 0, 0, 0, 0, 0, 1, 0, LU);
    applyStimulus("step_lu_hlt", 1, 0, 0, 0, 0, 0, 1, 0, HLT);
    checkScalar("perf_model", stall_cycles, perfExp(exp_perf));

    // Reset mid-halt returns to RUN
    applyStimulus("rst_halt",    0, 0, 0, 0, 0, 0, 1, 0, RST);
    applyStimulus("rst_halt_rn", 1, 0, 0, 0, 0, 0, 0, 0, ALL0);

    // Reset mid-stall discards the bubble
    applyStimulus("rst_lu_smp",  1, 1, 5, 5, 0, 0, 0, 0, ALL0);
    applyStimulus("rst_lu_rst",  0, 0, 0, 0, 0, 0, 0, 0, RST);
    applyStimulus("rst_lu_run",  1, 0, 0, 0, 0, 0, 0, 0, ALL0);

    // Watchdog with limit 4
    applyStimulus("wd_busy1", 1, 0, 0, 0, 0, 1, 0, 0, FRZ);
    applyStimulus("wd_busy2", 1, 0, 0, 0, 0, 1, 0, 0, FRZ);
    applyStimulus("wd_busy3", 1, 0, 0, 0, 0, 1, 0, 0, FRZ);
    checkScalar("wd_after3", {31'd0, mem_timeout}, 32'd0);
    applyStimulus("wd_busy4", 1, 0, 0, 0, 0, 1, 0, 0, FRZ);
    checkScalar("wd_after4", {31'd0, mem_timeout}, 32'd1);
    applyStimulus("wd_busy5", 1, 0, 0, 0, 0, 1, 0, 0, FRZ);
    applyStimulus("wd_idle",  1, 0, 0, 0, 0, 0, 0, 0, ALL0);
    checkScalar("wd_sticky", {31'd0, mem_timeout}, 32'd1);
    checkScalar("perf_final", stall_cycles, perfExp(exp_perf));
    applyStimulus("wd_reset", 0, 0, 0, 0, 0, 0, 0, 0, RST);
    checkScalar("wd_cleared", {31'd0, mem_timeout}, 32'd0);
    checkScalar("perf_cleared", stall_cycles, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall controller for the 5-stage pipeline. It drives the `pause` inputs of the FI_ID, ID_EX, EX_MEM and MEM_WB stage registers, plus PC hold. It issues load-use bubbles, freezes the pipeline while data memory is busy, and supports debug halt and single-step. All hazard decisions are registered, so pause outputs never depend on values that pause itself masks.

## Interface
- `MEM_TIMEOUT`, default 1023: consecutive `dmem_busy_i` cycles after which `mem_timeout_o` sets.
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  reset; synchronous, active-low.
- `if_rs_i`  in  6  rs index of the raw fetched instruction (pre-FI_ID); 0 means unused.
- `if_rt_i`  in  6  rt index of the raw fetched instruction; 0 means unused.
- `id_load_i`  in  1  instruction decoded in ID is a load.
- `id_dest_i`  in  6  destination index of that load.
- `dmem_busy_i`  in  1  data memory busy. It is registered inside the memory, and the memory latches its own request.
- `halt_req_i`  in  1  debug halt request (level).
- `step_i`  in  1  single-step pulse; honoured only in HALT.
- `pc_hold_o`  out  1  PC does not advance.
- `pause_fi_id_o`, `pause_id_ex_o`, `pause_ex_mem_o`, `pause_mem_wb_o`  out  1 each  stage-register pause (hold and zero outputs).
- `halted_o`  out  1  core is in HALT.
- `mem_timeout_o`  out  1  sticky memory-timeout error.
- `stall_cycles_o`  out  32  perf counter (see Configuration).

## Operation
- **States:** RUN, LU_STALL, HALT, STEP.
- **Hazard hit:** `id_load_i` is 1, `id_dest_i` is not 0, and `id_dest_i` equals a nonzero `if_rs_i` or `if_rt_i`. Evaluated only in RUN/STEP, on cycles with `dmem_busy_i` = 0.
- **RUN:**
  - Outputs are all 0.
  - On a hazard hit, go to LU_STALL.
  - Otherwise, if `halt_req_i` = 1, go to HALT.
  - A hazard hit takes priority over halt.
- **LU_STALL (one cycle):**
  - `pc_hold_o` = 1 and `pause_fi_id_o` = 1; the other pauses are 0.
  - The bubble enters ID_EX.
  - Exit to HALT if `halt_req_i` = 1, else to RUN.
- **HALT:**
  - `pc_hold_o` and all four pauses are 1; `halted_o` = 1.
  - `step_i` = 1 moves to STEP.
  - `halt_req_i` = 0 moves to RUN.
  - `step_i` takes priority.
- **STEP (one cycle):**
  - Outputs are as in RUN.
  - On a hazard hit, go to LU_STALL.
  - Otherwise go to HALT if `halt_req_i` = 1, else to RUN.
- **Memory freeze overlay:**
  - Whenever `dmem_busy_i` = 1, in any state, `pc_hold_o` and all four pauses are 1.
  - The state register holds, so a pending LU_STALL or STEP is not consumed.
  - `halted_o` keeps reflecting the state.
- **Watchdog:**
  - Counts consecutive cycles with `dmem_busy_i` = 1, saturating.
  - Clears on the first cycle with `dmem_busy_i` = 0.
  - `mem_timeout_o` sets when the count reaches `MEM_TIMEOUT` and clears only on reset.
  - The freeze persists regardless.

## Timing
- **Pause outputs:** combinational from the state register, `dmem_busy_i` and `rst`. No combinational path from any other input.
- **Hazard response:** a hazard sampled at edge t gives exactly one stall cycle, t+1.
- **Halt latency:** HALT is entered one cycle after `halt_req_i` is sampled in RUN.
- **Freeze release:** on the first cycle with `dmem_busy_i` = 0, pauses drop in that same cycle.
- **Reset (`rst` = 0):**
  - `pc_hold_o` = 1 and all pauses = 1.
  - `halted_o` = 0, `mem_timeout_o` = 0, `stall_cycles_o` = 0.
  - State returns to RUN, watchdog count = 0.
  - Reset mid-stall or mid-halt discards the pending stall or step.

## Configuration
- **`PIPE_PERF_CNT_EN` defined:**
  - `stall_cycles_o` increments by 1 on every cycle with `rst` = 1 and `pc_hold_o` = 1, excluding HALT cycles that are not frozen.
  - It wraps at 2^32.
- **Not defined:** `stall_cycles_o` is tied to 0 and no counter flops exist.

## Structure
- **Package `pipe_pkg`:**
  - `REG_IDX_W` = 6.
  - The state enum (RUN, LU_STALL, HALT, STEP).
  - Default `MEM_TIMEOUT`.
- **Sub-module `pipe_wdog`:** the saturating busy counter and sticky `mem_timeout_o`. Everything else is inline.

## Test plan
- **Load-use:** `id_load_i`=1, `id_dest_i`=5, `if_rt_i`=5 at edge t -> cycle t+1 has `pc_hold_o`=1 and `pause_fi_id_o`=1, others 0; cycle t+2 is all 0.
- **Register 0 never hazards:** `id_dest_i`=0, `if_rs_i`=0 -> no stall ever.
- **Freeze over a pending stall:** hazard at t, `dmem_busy_i`=1 for cycles t+1..t+3 -> all pauses 1 for t+1..t+3, LU_STALL in t+4, RUN in t+5.
- **Halt, step, resume:**
  - `halt_req_i`=1 -> `halted_o`=1 from the next cycle with all pauses 1.
  - `step_i` pulse -> exactly one cycle with all outputs 0, then HALT again.
  - `halt_req_i`=0 -> RUN.
- **Watchdog:** `MEM_TIMEOUT`=4, `dmem_busy_i` held high -> `mem_timeout_o` rises after 4 busy cycles and stays 1 after busy drops, until `rst`=0.
- **Perf counter:** with `PIPE_PERF_CNT_EN`, 3 freeze cycles + 1 LU_STALL -> `stall_cycles_o`=4; without the macro it reads 0. A reset mid-halt returns `halted_o` to 0 and the state to RUN.
